// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM access controller: FSM state encoding and
// default geometry of the attached synchronous-read SRAM.
package sram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_DATA_DEPTH = 4096;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/sram_access_ctrl.sv
// Single-outstanding initiator for a synchronous-read SRAM: one request port,
// one read-response port, and range screening so the SRAM is never over-indexed.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DATA_DEPTH = DEF_DATA_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  oob_err,
  output logic                  mem_we_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // One extra bit so a depth of 2^ADDR_WIDTH compares without wrapping to 0.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  state_e                state_q, state_d;
  logic                  mem_we_n_q, mem_we_n_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  oob_err_q, oob_err_d;
  logic                  rd_oob_q, rd_oob_d;
  logic                  req_oob;

  assign req_oob = ({1'b0, req_addr} >= DEPTH_EXT);

  always_comb begin
    state_d     = state_q;
    mem_we_n_d  = mem_we_n_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    oob_err_d   = oob_err_q;
    rd_oob_d    = rd_oob_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_oob) begin
            oob_err_d = 1'b1;
          end
          if (req_we) begin
            // Out-of-range writes are consumed silently: no SRAM cycle at all.
            if (!req_oob) begin
              mem_addr_d  = req_addr;
              mem_wdata_d = req_wdata;
              mem_we_n_d  = 1'b0;
              state_d     = ST_WRITE;
            end
          end else begin
            mem_addr_d = req_oob ? '0 : req_addr;
            rd_oob_d   = req_oob;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_WRITE: begin
        mem_we_n_d = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        rsp_rdata_d = rd_oob_q ? '0 : mem_rdata;
        rsp_err_d   = rd_oob_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        mem_we_n_d  = 1'b1;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_we_n_q  <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      oob_err_q   <= 1'b0;
      rd_oob_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_n_q  <= mem_we_n_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      oob_err_q   <= oob_err_d;
      rd_oob_q    <= rd_oob_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign oob_err   = oob_err_q;
  assign mem_we_n  = mem_we_n_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with an attached synchronous-read SRAM
// model and a transaction-level reference of memory contents and responses.
module tb_sram_access_ctrl;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 4096;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          oob_err;
  logic          mem_we_n;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  sram_access_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DATA_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .oob_err   (oob_err),
    .mem_we_n  (mem_we_n),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read SRAM attached to the controller.
  logic [DW-1:0] sram [0:DEPTH-1];
  initial begin
    for (int i = 0; i < DEPTH; i++) sram[i] = '0;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (!mem_we_n) sram[mem_addr[11:0]] <= mem_wdata;
    mem_rdata <= sram[mem_addr[11:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: contents of memory as seen by a correct controller, queue of
  // responses owed, sticky error flag and the expected write-enable pulse.
  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] model_mem [0:DEPTH-1];
  rsp_t          exp_q[$];
  rsp_t          exp_e;
  logic          model_oob;
  logic          we_stage;
  logic          commit_stage;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;
  logic          prev_hold;
  logic [DW-1:0] prev_data;
  logic          prev_err;
  logic          acc_oob;

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  end

  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      model_oob    = 1'b0;
      we_stage     = 1'b0;
      commit_stage = 1'b0;
      prev_hold    = 1'b0;
    end else begin
      check("mem_we_n", 32'(mem_we_n), we_stage ? 32'd0 : 32'd1);
      if (we_stage) begin
        check("mem_addr_wr", 32'(mem_addr), 32'(pend_addr));
        check("mem_wdata_wr", 32'(mem_wdata), 32'(pend_data));
      end
      if (commit_stage) model_mem[pend_addr[11:0]] = pend_data;
      commit_stage = we_stage;
      we_stage     = 1'b0;

      check("oob_err", 32'(oob_err), 32'(model_oob));
      check("ready_and_rsp", 32'(req_ready & rsp_valid), 32'd0);

      if (prev_hold) begin
        check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        check("rsp_hold_data", 32'(rsp_rdata), 32'(prev_data));
        check("rsp_hold_err", 32'(rsp_err), 32'(prev_err));
      end

      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got data 0x%0h err %0d, required no response", rsp_rdata, rsp_err);
        end else begin
          exp_e = exp_q.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(exp_e.data));
          check("rsp_err", 32'(rsp_err), 32'(exp_e.err));
          $display("rsp  data=0x%04h err=%0d (expected 0x%04h err=%0d)", rsp_rdata, rsp_err, exp_e.data, exp_e.err);
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_data = rsp_rdata;
      prev_err  = rsp_err;

      if (req_valid && req_ready) begin
        acc_oob = (32'(req_addr) >= DEPTH);
        if (acc_oob) model_oob = 1'b1;
        if (req_we) begin
          if (!acc_oob) begin
            we_stage  = 1'b1;
            pend_addr = req_addr;
            pend_data = req_wdata;
          end
          $display("req  write addr=0x%04h data=0x%04h oob=%0d", req_addr, req_wdata, acc_oob);
        end else begin
          exp_e.err  = acc_oob;
          exp_e.data = acc_oob ? '0 : model_mem[req_addr[11:0]];
          exp_q.push_back(exp_e);
          $display("req  read  addr=0x%04h oob=%0d", req_addr, acc_oob);
        end
      end
    end
  end

  // Present a request from a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic in_range);
    send(1'b1, a, d);
    if (in_range) begin
      check("wr_pulse_low", 32'(mem_we_n), 32'd0);
      @(negedge clk);
      check("wr_pulse_end", 32'(mem_we_n), 32'd1);
    end else begin
      check("oob_wr_no_pulse", 32'(mem_we_n), 32'd1);
      check("oob_wr_idle", 32'(req_ready), 32'd1);
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                         input logic exp_err, input int hold);
    int lat;
    send(1'b0, a, '0);
    rsp_ready = (hold == 0);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_data_lit", 32'(rsp_rdata), 32'(exp_d));
    check("rd_err_lit", 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_rdata), 32'(exp_d));
      check("hold_not_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_dropped", 32'(rsp_valid), 32'd0);
    check("accept_resumes", 32'(req_ready), 32'd1);
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_we_n", 32'(mem_we_n), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_idle", 32'(req_ready), 32'd1);
    check("rst_oob_err", 32'(oob_err), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    check("reset_we_n", 32'(mem_we_n), 32'd1);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_oob_err", 32'(oob_err), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);

    do_write(16'h0010, 16'h1234, 1'b1);
    do_read(16'h0010, 16'h1234, 1'b0, 0);

    do_read(16'h0010, 16'h1234, 1'b0, 5);

    do_write(16'h1000, 16'hBEEF, 1'b0);
    check("oob_err_set", 32'(oob_err), 32'd1);
    do_read(16'h1000, 16'h0000, 1'b1, 0);
    do_read(16'hFFFF, 16'h0000, 1'b1, 0);

    do_write(16'h0005, 16'hAAAA, 1'b1);
    do_read(16'h0005, 16'hAAAA, 1'b0, 0);
    do_write(16'h0005, 16'h5555, 1'b1);
    do_read(16'h0005, 16'h5555, 1'b0, 0);

    do_write(16'h0FFF, 16'hC0DE, 1'b1);
    do_read(16'h0FFF, 16'hC0DE, 1'b0, 0);

    do_write(16'h0020, 16'h1111, 1'b1);
    send(1'b1, 16'h0020, 16'hDEAD);
    check("abort_wr_low", 32'(mem_we_n), 32'd0);
    do_reset();
    do_read(16'h0020, 16'h1111, 1'b0, 0);

    send(1'b0, 16'h0010, '0);
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("resp_before_rst", 32'(rsp_valid), 32'd1);
    do_reset();
    do_read(16'h0010, 16'h1234, 1'b0, 0);

    repeat (2) @(negedge clk);
    check("no_pending_rsp", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
